countdown_timer: RTL

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// Countdown timer with a BCD SS.t display and a 0.1 s prescaler.
// Supports load/start/stop control, pause/resume, and an expiry level plus a one-cycle strobe.
module countdown_timer #(
  parameter logic [23:0] PRESCALE = 24'd10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] preset_tens,
  input  logic [3:0] preset_ones,
  input  logic [3:0] preset_tenths,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] digit_tens,
  output logic [3:0] digit_ones,
  output logic [3:0] digit_tenths,
  output logic       running,
  output logic       expired,
  output logic       expire_pulse
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_e;

  state_e      state_q, state_d;
  logic [23:0] presc_q, presc_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic [3:0]  tenths_q, tenths_d;
  logic        pulse_q, pulse_d;

  logic        tick;
  logic        is_zero;
  logic        last_step;
  logic [3:0]  dec_tens, dec_ones, dec_tenths;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  assign tick      = (state_q == RUN) && (presc_q == PRESCALE - 24'd1);
  assign is_zero   = (tens_q == 4'd0) && (ones_q == 4'd0) && (tenths_q == 4'd0);
  assign last_step = (tens_q == 4'd0) && (ones_q == 4'd0) && (tenths_q == 4'd1);

  // BCD borrow chain: tenths borrow from ones, ones borrow from tens.
  always_comb begin
    dec_tens   = tens_q;
    dec_ones   = ones_q;
    dec_tenths = tenths_q;
    if (tenths_q != 4'd0) begin
      dec_tenths = tenths_q - 4'd1;
    end else begin
      dec_tenths = 4'd9;
      if (ones_q != 4'd0) begin
        dec_ones = ones_q - 4'd1;
      end else begin
        dec_ones = 4'd9;
        dec_tens = tens_q - 4'd1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    tens_d   = tens_q;
    ones_d   = ones_q;
    tenths_d = tenths_q;
    pulse_d  = 1'b0;
    if (load) begin
      tens_d   = clamp_bcd(preset_tens);
      ones_d   = clamp_bcd(preset_ones);
      tenths_d = clamp_bcd(preset_tenths);
      presc_d  = 24'd0;
      state_d  = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !stop && !is_zero) begin
            state_d = RUN;
            presc_d = 24'd0;
          end
        end
        // Resuming keeps the prescaler so the interrupted tick period completes.
        PAUSE: begin
          if (start && !stop && !is_zero) state_d = RUN;
        end
        RUN: begin
          if (tick) begin
            presc_d = 24'd0;
            if (!is_zero) begin
              tens_d   = dec_tens;
              ones_d   = dec_ones;
              tenths_d = dec_tenths;
            end
            if (last_step) begin
              state_d = EXPIRED;
              pulse_d = 1'b1;
            end else if (stop) begin
              state_d = PAUSE;
            end
          end else begin
            presc_d = presc_q + 24'd1;
            if (stop) state_d = PAUSE;
          end
        end
        EXPIRED: begin
          state_d = EXPIRED;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      presc_q  <= 24'd0;
      tens_q   <= 4'd0;
      ones_q   <= 4'd0;
      tenths_q <= 4'd0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      tenths_q <= tenths_d;
      pulse_q  <= pulse_d;
    end
  end

  assign digit_tens   = tens_q;
  assign digit_ones   = ones_q;
  assign digit_tenths = tenths_q;
  assign running      = (state_q == RUN);
  assign expired      = (state_q == EXPIRED);
  assign expire_pulse = pulse_q;

endmodule
